// File: rtl/block_fifo.sv
// Single-clock FIFO, 2**ASIZE x DSIZE, registered read data, fill-level output.
// Define BLOCK_FIFO_STATUS_EN to add sticky overflow/underflow flags (ovf, udf).
module block_fifo #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DSIZE-1:0] wdata,
    input  logic             winc,
    output logic             wfull,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             rempty,
    output logic [ASIZE:0]   level
`ifdef BLOCK_FIFO_STATUS_EN
    ,
    output logic             ovf,
    output logic             udf
`endif
);

    localparam logic [ASIZE:0] PTR_ONE = 1;

    logic [DSIZE-1:0] mem [2**ASIZE];
    logic [ASIZE:0]   wptr;
    logic [ASIZE:0]   rptr;
    logic             wr_en;
    logic             rd_en;

    // Flags come from the registered pointers only, so wdata never reaches rdata.
    always_comb begin
        rempty = (wptr == rptr);
        wfull  = (wptr[ASIZE] != rptr[ASIZE]) &&
                 (wptr[ASIZE-1:0] == rptr[ASIZE-1:0]);
        level  = wptr - rptr;
        wr_en  = winc && !wfull;
        rd_en  = rinc && !rempty;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr[ASIZE-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            rdata <= '0;
        end else begin
            if (wr_en) begin
                wptr <= wptr + PTR_ONE;
            end
            if (rd_en) begin
                rdata <= mem[rptr[ASIZE-1:0]];
                rptr  <= rptr + PTR_ONE;
            end
        end
    end

`ifdef BLOCK_FIFO_STATUS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            if (winc && wfull) begin
                ovf <= 1'b1;
            end
            if (rinc && rempty) begin
                udf <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_block_fifo.sv
// Directed self-checking bench for block_fifo (default depth 16, 8-bit data).
module tb_block_fifo;

    logic       clk;
    logic       rst_n;
    logic [7:0] wdata;
    logic       winc;
    logic       wfull;
    logic       rinc;
    logic [7:0] rdata;
    logic       rempty;
    logic [4:0] level;
`ifdef BLOCK_FIFO_STATUS_EN
    logic       ovf;
    logic       udf;
`endif

    int errors = 0;
    int checks = 0;

    block_fifo #(.DSIZE(8), .ASIZE(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .wdata  (wdata),
        .winc   (winc),
        .wfull  (wfull),
        .rinc   (rinc),
        .rdata  (rdata),
        .rempty (rempty),
        .level  (level)
`ifdef BLOCK_FIFO_STATUS_EN
        ,
        .ovf    (ovf),
        .udf    (udf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock edge with the given strobes, then sample 1ns after the edge.
    task automatic step(input logic w, input logic r, input logic [7:0] d);
        winc  = w;
        rinc  = r;
        wdata = d;
        @(posedge clk);
        #1;
        winc = 1'b0;
        rinc = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1;
        winc  = 1'b0;
        rinc  = 1'b0;
        wdata = 8'h00;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rempty", rempty, 1);
        check("rst_wfull", wfull, 0);
        check("rst_level", level, 0);
        check("rst_rdata", rdata, 8'h00);
        rst_n = 1'b1;

        // Basic ordering
        step(1, 0, 8'h33);
        step(1, 0, 8'h34);
        check("basic_level2", level, 2);
        check("basic_notempty", rempty, 0);
        step(0, 1, 8'h00);
        check("basic_rd0", rdata, 8'h33);
        step(0, 1, 8'h00);
        check("basic_rd1", rdata, 8'h34);
        check("basic_empty", rempty, 1);
        check("basic_level0", level, 0);

        // Fill to full, drop a 17th write, drain in order
        for (int i = 0; i < 16; i++) step(1, 0, 8'(i));
        check("full_flag", wfull, 1);
        check("full_level", level, 16);
        step(1, 0, 8'hAA);
        check("full_drop_level", level, 16);
        check("full_drop_flag", wfull, 1);
`ifdef BLOCK_FIFO_STATUS_EN
        check("ovf_set", ovf, 1);
        check("udf_clear", udf, 0);
`endif
        for (int i = 0; i < 16; i++) begin
            step(0, 1, 8'h00);
            check("drain_data", rdata, 32'(i));
        end
        check("drain_empty", rempty, 1);

        // Read on empty: rdata and pointers untouched
        step(0, 1, 8'h00);
        check("empty_rd_rdata", rdata, 8'h0F);
        check("empty_rd_level", level, 0);
        check("empty_rd_rempty", rempty, 1);
`ifdef BLOCK_FIFO_STATUS_EN
        check("udf_set", udf, 1);
`endif
        step(1, 0, 8'h55);
        step(0, 1, 8'h00);
        check("empty_rd_next", rdata, 8'h55);

        // Steady-state simultaneous access across pointer wrap
        step(1, 0, 8'h80);
        step(1, 0, 8'h81);
        step(1, 0, 8'h82);
        check("wrap_preload", level, 3);
        for (int i = 0; i < 40; i++) begin
            step(1, 1, 8'(8'h83 + i));
            check("wrap_data", rdata, 32'(8'h80 + i));
            check("wrap_level", level, 3);
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 8'h00);
            check("wrap_tail", rdata, 32'(8'hA8 + i));
        end
        check("wrap_empty", rempty, 1);

        // Simultaneous access at full: read wins, write dropped
        for (int i = 0; i < 16; i++) step(1, 0, 8'(8'h10 + i));
        check("bfull_flag", wfull, 1);
        step(1, 1, 8'hEE);
        check("bfull_rdata", rdata, 8'h10);
        check("bfull_level", level, 15);
        check("bfull_wfull", wfull, 0);
        for (int i = 1; i < 16; i++) begin
            step(0, 1, 8'h00);
            check("bfull_drain", rdata, 32'(8'h10 + i));
        end
        check("bfull_empty", rempty, 1);

        // Simultaneous access at empty: write only, no fall-through
        step(1, 1, 8'h77);
        check("bempty_rdata", rdata, 8'h1F);
        check("bempty_level", level, 1);
        check("bempty_rempty", rempty, 0);
        step(0, 1, 8'h00);
        check("bempty_next", rdata, 8'h77);

        // Asynchronous reset mid-operation
        step(1, 0, 8'hC1);
        step(1, 0, 8'hC2);
        check("mid_level_pre", level, 2);
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_rempty", rempty, 1);
        check("mid_rst_wfull", wfull, 0);
        check("mid_rst_level", level, 0);
        check("mid_rst_rdata", rdata, 8'h00);
`ifdef BLOCK_FIFO_STATUS_EN
        check("mid_rst_ovf", ovf, 0);
        check("mid_rst_udf", udf, 0);
`endif
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step(1, 0, 8'h42);
        check("post_rst_level", level, 1);
        step(0, 1, 8'h00);
        check("post_rst_rdata", rdata, 8'h42);
        check("post_rst_empty", rempty, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/block_fifo.md
Name: block_fifo

Overview:
Single-clock synchronous FIFO for byte-wide data buffering between producer and consumer logic, e.g. SPI slave and sample buffering.
- Storage: 2**ASIZE entries, DSIZE bits wide.
- Handshake: write/read increment strobes.
- Status: full/empty flags and a fill-level output.
- Reads are registered: one cycle of latency.

Parameters:
DSIZE, 8, data width in bits
ASIZE, 4, address width; depth = 2**ASIZE (16)

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
wdata  input  DSIZE  write data
winc  input  1  write request, sampled on clk rising edge
wfull  output  1  FIFO full
rinc  input  1  read request, sampled on clk rising edge
rdata  output  DSIZE  read data register
rempty  output  1  FIFO empty
level  output  ASIZE+1  current number of stored entries, 0..2**ASIZE

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset (rst_n=0, asynchronous, any time, including mid-operation):
  - write/read pointers = 0; rdata = 0; rempty = 1; wfull = 0; level = 0.
  - Memory contents are not cleared; they are don't-care.
- Pointers: wptr and rptr are ASIZE+1-bit binary counters.
  - Memory address = low ASIZE bits.
  - MSB distinguishes wrap; natural wrap from 2**(ASIZE+1)-1 to 0.
- Flags, combinational from registered pointers:
  - rempty = (wptr == rptr).
  - wfull = (wptr[ASIZE] != rptr[ASIZE]) && (wptr[ASIZE-1:0] == rptr[ASIZE-1:0]).
  - level = wptr - rptr, modulo 2**(ASIZE+1).
- Write accept:
  - If winc=1 and wfull=0 at a rising edge: mem[wptr addr] <= wdata, wptr increments.
  - If wfull=1, the write is dropped silently: no pointer or memory change.
- Read accept:
  - If rinc=1 and rempty=0 at a rising edge: rdata <= mem[rptr addr], rptr increments.
  - Data is valid on rdata after that edge (1-cycle latency).
  - If rempty=1, the read is ignored and rdata holds its previous value.
  - rdata holds its value whenever no read is accepted.
- Simultaneous winc and rinc:
  - Neither empty nor full: both accepted in the same cycle; level unchanged.
  - Empty: only the write is accepted; the read is ignored, with no fall-through of the new word.
  - Full: only the read is accepted; the write is dropped.
- Flag timing: flags and level reflect pointer state and update in the cycle after the accepting edge.
- No combinational path from wdata to rdata.

Optional Feature:
Macro: BLOCK_FIFO_STATUS_EN.
- Defined: adds two sticky outputs, ovf and udf (1 bit each), both 0 after reset.
  - ovf sets at the rising edge when winc=1 while wfull=1.
  - udf sets at the rising edge when rinc=1 while rempty=1.
  - Both remain set until rst_n is asserted.
- Not defined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles mid-run -> rempty=1, wfull=0, level=0, rdata=0x00 immediately (asynchronous).
- Basic order:
  - Write 0x33, then 0x34 (winc one cycle each) -> level=2, rempty=0.
  - rinc one cycle -> rdata=0x33 after the edge.
  - rinc again -> rdata=0x34, rempty=1, level=0.
- Full:
  - Write 16 words 0x00..0x0F -> wfull=1, level=16.
  - A 17th write of 0xAA is dropped (ovf=1 if BLOCK_FIFO_STATUS_EN).
  - Draining 16 reads returns 0x00..0x0F in order.
- Empty read: rinc on empty FIFO -> rdata unchanged, pointers unchanged (udf=1 if enabled).
- Wrap-around and simultaneous access:
  - Run 40 cycles with winc=rinc=1 after pre-loading 3 words, writing an incrementing pattern.
  - Required: level stays 3, read sequence is the exact write sequence delayed by 3, pointer wrap is transparent.
- Boundary simultaneous access:
  - At full with winc=rinc=1 -> read accepted, write dropped, level=15.
  - At empty with winc=rinc=1 -> write accepted, rdata unchanged, level=1.
